// File: rtl/nand_target_emu.sv
// NAND flash target emulator: decodes a host-driven NAND bus sampled in the clk domain and serves a small page array.
// Optional build macro NAND_EMU_ERR_INJ_EN adds err_inj_i to flip bit0 of the first byte of a read.
module nand_target_emu #(
  parameter int unsigned PAGE_BYTES = 64,
  parameter int unsigned PAGES      = 16,
  parameter int unsigned T_R        = 32,
  parameter int unsigned T_PROG     = 64,
  parameter int unsigned T_RST      = 8,
  parameter logic [31:0] ID_WORD    = 32'hECD35195
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ce_n,
  input  logic       cle,
  input  logic       ale,
  input  logic       we_n,
  input  logic       re_n,
  input  logic [7:0] dq_i,
  output logic [7:0] dq_o,
  output logic       dq_oe,
  output logic       rb_n
`ifdef NAND_EMU_ERR_INJ_EN
  ,
  input  logic       err_inj_i
`endif
);

  localparam int unsigned CW = $clog2(PAGE_BYTES);
  localparam int unsigned RW = $clog2(PAGES);
  localparam int unsigned BW = 16;
  localparam int unsigned SW = 13;
  localparam logic [SW-1:0] BUS_IDLE = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

  typedef enum logic [2:0] {IDLE, ADDR, BUSY, RD_DATA, PROG_DATA, STATUS, ID} state_t;
  typedef enum logic [1:0] {P_READ, P_PROG, P_ID} pend_t;
  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_RST} op_t;

  logic [SW-1:0] sync1, sync2;
  logic          we_q, re_q;
  logic          ce_s, cle_s, ale_s, we_s, re_s;
  logic [7:0]    dq_s;

  state_t        state;
  pend_t         pend;
  op_t           op;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    addr_cnt;
  logic [1:0]    id_idx;
  logic [1:0]    id_sel;
  logic [BW-1:0] busy_cnt;
  logic [7:0]    page_reg [PAGE_BYTES];
  logic [7:0]    mem      [PAGES][PAGE_BYTES];

  logic          busy_c, we_rise_c, re_fall_c, re_rise_c, rd_reenter_c, oe_c, inj_c;
  logic [7:0]    dout_c;

`ifdef NAND_EMU_ERR_INJ_EN
  logic          err_flag;
`endif

  assign {ce_s, cle_s, ale_s, we_s, re_s, dq_s} = sync2;

  // Strobe edges only count while the synchronized chip enable is asserted
  assign busy_c       = (busy_cnt != '0);
  assign we_rise_c    = ~ce_s & we_s & ~we_q;
  assign re_fall_c    = ~ce_s & ~re_s & re_q & ~we_rise_c;
  assign re_rise_c    = ~ce_s & re_s & ~re_q;
  assign rd_reenter_c = (state == ADDR) && (pend == P_READ) && (addr_cnt == 2'd0) && re_fall_c;
  assign oe_c         = ((state == RD_DATA) || (state == STATUS) || (state == ID) || rd_reenter_c)
                        && ~ce_s && ~re_s;
  assign id_sel       = 2'd3 - id_idx;

  always_comb begin
    inj_c = 1'b0;
`ifdef NAND_EMU_ERR_INJ_EN
    inj_c = err_flag && (col == '0);
`endif
  end

  // Byte presented on DQ for the current read-type state
  always_comb begin
    dout_c = 8'h00;
    case (state)
      STATUS:  dout_c = busy_c ? 8'h80 : 8'hC0;
      ID:      dout_c = ID_WORD[{id_sel, 3'b000} +: 8];
      default: dout_c = page_reg[col] ^ {7'b0, inj_c};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1    <= BUS_IDLE;
      sync2    <= BUS_IDLE;
      we_q     <= 1'b1;
      re_q     <= 1'b1;
      state    <= IDLE;
      pend     <= P_READ;
      op       <= OP_RST;
      col      <= '0;
      row      <= '0;
      addr_cnt <= 2'd0;
      id_idx   <= 2'd0;
      busy_cnt <= '0;
      page_reg <= '{default: 8'hFF};
      dq_o     <= 8'h00;
      dq_oe    <= 1'b0;
      rb_n     <= 1'b1;
`ifdef NAND_EMU_ERR_INJ_EN
      err_flag <= 1'b0;
`endif
    end else begin
      sync1 <= {ce_n, cle, ale, we_n, re_n, dq_i};
      sync2 <= sync1;
      we_q  <= we_s;
      re_q  <= re_s;

      // Busy countdown; the pending operation takes effect on its last clk
      if (busy_c) begin
        if (busy_cnt == BW'(1)) begin
          busy_cnt <= '0;
          rb_n     <= 1'b1;
          case (op)
            OP_READ: begin
              page_reg <= mem[row];
              state    <= RD_DATA;
            end
            OP_PROG: begin
              mem[row] <= page_reg;
              state    <= (state == STATUS) ? STATUS : IDLE;
            end
            default: state <= (state == STATUS) ? STATUS : IDLE;
          endcase
        end else begin
          busy_cnt <= busy_cnt - BW'(1);
        end
      end

      if (we_rise_c) begin
        if (cle_s && !ale_s) begin
          if (dq_s == 8'h70) begin
            state    <= STATUS;
            addr_cnt <= 2'd0;
          end else if (dq_s == 8'hFF) begin
            state    <= BUSY;
            op       <= OP_RST;
            busy_cnt <= BW'(T_RST);
            rb_n     <= 1'b0;
            addr_cnt <= 2'd0;
          end else if (!busy_c) begin
            addr_cnt <= 2'd0;
            case (dq_s)
              8'h00: begin
                state <= ADDR;
                pend  <= P_READ;
              end
              8'h80: begin
                state    <= ADDR;
                pend     <= P_PROG;
                page_reg <= '{default: 8'hFF};
              end
              8'h90: begin
                state <= ADDR;
                pend  <= P_ID;
              end
              8'h30: begin
                if (state == ADDR && pend == P_READ) begin
                  state    <= BUSY;
                  op       <= OP_READ;
                  busy_cnt <= BW'(T_R);
                  rb_n     <= 1'b0;
`ifdef NAND_EMU_ERR_INJ_EN
                  err_flag <= err_inj_i;
`endif
                end else begin
                  state <= IDLE;
                end
              end
              8'h10: begin
                if ((state == ADDR && pend == P_PROG) || state == PROG_DATA) begin
                  state    <= BUSY;
                  op       <= OP_PROG;
                  busy_cnt <= BW'(T_PROG);
                  rb_n     <= 1'b0;
                end else begin
                  state <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end else if (ale_s && !cle_s) begin
          if (!busy_c && state == ADDR) begin
            if (pend == P_ID) begin
              state  <= ID;
              id_idx <= 2'd0;
            end else begin
              if (addr_cnt == 2'd0) col <= dq_s[CW-1:0];
              if (addr_cnt == 2'd2) row <= dq_s[RW-1:0];
              if (addr_cnt != 2'd3) addr_cnt <= addr_cnt + 2'd1;
            end
          end
        end else if (!cle_s && !ale_s) begin
          if (!busy_c && ((state == ADDR && pend == P_PROG) || state == PROG_DATA)) begin
            page_reg[col] <= dq_s;
            col           <= col + CW'(1);
            state         <= PROG_DATA;
          end
        end
      end else if (rd_reenter_c) begin
        state <= RD_DATA;
      end else if (re_rise_c) begin
        if (state == RD_DATA) begin
          col <= col + CW'(1);
`ifdef NAND_EMU_ERR_INJ_EN
          err_flag <= 1'b0;
`endif
        end
        if (state == ID) id_idx <= id_idx + 2'd1;
      end

      dq_oe <= oe_c;
      dq_o  <= oe_c ? dout_c : 8'h00;
    end
  end

endmodule

// File: tb/tb_nand_target_emu.sv
// Scoreboard bench for nand_target_emu: bus-cycle driver, DQ/R-B monitor and a byte-array page model.
module tb_nand_target_emu;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ce_n, cle, ale, we_n, re_n;
  logic [7:0] dq_i;
  logic [7:0] dq_o;
  logic       dq_oe, rb_n;
`ifdef NAND_EMU_ERR_INJ_EN
  logic       err_inj_i;
`endif

  nand_target_emu dut (
    .clk   (clk),
    .rstn  (rstn),
    .ce_n  (ce_n),
    .cle   (cle),
    .ale   (ale),
    .we_n  (we_n),
    .re_n  (re_n),
    .dq_i  (dq_i),
    .dq_o  (dq_o),
    .dq_oe (dq_oe),
    .rb_n  (rb_n)
`ifdef NAND_EMU_ERR_INJ_EN
    ,
    .err_inj_i (err_inj_i)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int         busy_q [$];
  logic [7:0] mem_m [16][64];
  logic [7:0] tmp [64];
  logic [7:0] idb [4];
  logic       oe_prev = 1'b0;
  int         busy_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one DQ byte per output-enable rising edge, one busy length per R/B_n low run
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (dq_oe && !oe_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_oe got %0h expected none", dq_o);
        end else begin
          chk("dq_o", 32'(dq_o), 32'(exp_q.pop_front()));
        end
      end
      if (!rb_n) busy_len++;
      else if (busy_len != 0) begin
        if (busy_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_busy got %0d expected none", busy_len);
        end else begin
          chk("busy_len", 32'(busy_len), 32'(busy_q.pop_front()));
        end
        busy_len = 0;
      end
    end
    oe_prev = dq_oe;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wcyc(input logic c, input logic a, input logic [7:0] d);
    cle = c; ale = a; dq_i = d;
    clk_n(2);
    we_n = 1'b0;
    clk_n(4);
    we_n = 1'b1;
    clk_n(4);
    cle = 1'b0; ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d); wcyc(1'b1, 1'b0, d); endtask
  task automatic adr(input logic [7:0] d); wcyc(1'b0, 1'b1, d); endtask
  task automatic din(input logic [7:0] d); wcyc(1'b0, 1'b0, d); endtask

  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    re_n = 1'b0;
    clk_n(5);
    chk("oe_during_re", 32'(dq_oe), 32'd1);
    re_n = 1'b1;
    clk_n(4);
    chk("oe_after_re", 32'(dq_oe), 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3000; i++) begin
      if (rb_n) break;
      clk_n(1);
    end
    chk("ready_timeout", 32'(rb_n), 32'd1);
    clk_n(2);
  endtask

  task automatic addr3(input logic [7:0] c, input logic [7:0] r);
    adr(c); adr(8'($urandom)); adr(r);
  endtask

  task automatic open_read(input logic [7:0] c, input logic [7:0] r);
    cmd(8'h00); addr3(c, r); cmd(8'h30);
    busy_q.push_back(32);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c, n, r, l;
    logic [7:0] d;
    idb[0] = 8'hEC; idb[1] = 8'hD3; idb[2] = 8'h51; idb[3] = 8'h95;
    rstn = 1'b0; ce_n = 1'b0; cle = 1'b0; ale = 1'b0; we_n = 1'b1; re_n = 1'b1; dq_i = 8'h00;
`ifdef NAND_EMU_ERR_INJ_EN
    err_inj_i = 1'b0;
`endif
    clk_n(5);
    chk("rst_dq_o", 32'(dq_o), 32'd0);
    chk("rst_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst_rb_n", 32'(rb_n), 32'd1);
    rstn = 1'b1;
    clk_n(4);

    // Status after reset
    cmd(8'h70);
    rd(8'hC0);
    chk("rb_n_idle", 32'(rb_n), 32'd1);

    // Program page 3 with an incrementing pattern, status polled while busy
    cmd(8'h80); addr3(8'h00, 8'h03);
    for (int i = 0; i < 64; i++) din(8'(i));
    cmd(8'h10);
    busy_q.push_back(64);
    cmd(8'h70);
    rd(8'h80);
    wait_ready();
    for (int i = 0; i < 64; i++) mem_m[3][i] = 8'(i);

    open_read(8'h00, 8'h03);
    wait_ready();
    for (int i = 0; i < 64; i++) rd(mem_m[3][i]);

    // Column wrap on read
    open_read(8'h3E, 8'h03);
    wait_ready();
    rd(8'h3E); rd(8'h3F); rd(8'h00); rd(8'h01);

    // Page 5: full program, then a reset-aborted program leaves it intact
    cmd(8'h80); addr3(8'h00, 8'h05);
    for (int i = 0; i < 64; i++) begin
      d = 8'($urandom);
      din(d);
      mem_m[5][i] = d;
    end
    cmd(8'h10);
    busy_q.push_back(64);
    wait_ready();
    cmd(8'h80); addr3(8'h00, 8'h05);
    for (int i = 0; i < 8; i++) din(8'($urandom));
    cmd(8'hFF);
    busy_q.push_back(8);
    wait_ready();
    open_read(8'h00, 8'h05);
    cmd(8'h70);
    rd(8'h80);
    wait_ready();
    for (int i = 0; i < 64; i++) rd(mem_m[5][i]);

    // Read ID with wrap, then strobes while deselected must be ignored
    cmd(8'h90); adr(8'h00);
    for (int i = 0; i < 5; i++) rd(idb[i % 4]);
    ce_n = 1'b1;
    clk_n(4);
    cle = 1'b1; dq_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      clk_n(2); we_n = 1'b0; clk_n(4); we_n = 1'b1;
    end
    clk_n(2);
    re_n = 1'b0;
    clk_n(5);
    chk("oe_ce_high", 32'(dq_oe), 32'd0);
    re_n = 1'b1; cle = 1'b0;
    clk_n(4);
    ce_n = 1'b0;
    clk_n(4);
    chk("rb_n_ce_high", 32'(rb_n), 32'd1);
    rd(idb[1]);
    rd(idb[2]);

`ifdef NAND_EMU_ERR_INJ_EN
    // Injected bit0 flip on the first byte only, then an exact re-read
    cmd(8'h00); addr3(8'h00, 8'h03);
    err_inj_i = 1'b1;
    cmd(8'h30);
    err_inj_i = 1'b0;
    busy_q.push_back(32);
    wait_ready();
    rd(8'h01); rd(8'h01); rd(8'h02); rd(8'h03);
    open_read(8'h00, 8'h03);
    wait_ready();
    rd(8'h00); rd(8'h01);
`endif

    // Randomized partial programs and reads against the page model
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(0, 15);
      c = $urandom_range(0, 255);
      n = $urandom_range(1, 70);
      for (int j = 0; j < 64; j++) tmp[j] = 8'hFF;
      cmd(8'h80); addr3(8'(c), 8'(p + 16 * $urandom_range(0, 15)));
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        din(d);
        tmp[(c + i) % 64] = d;
      end
      cmd(8'h10);
      busy_q.push_back(64);
      wait_ready();
      for (int j = 0; j < 64; j++) mem_m[p][j] = tmp[j];
      if ($urandom_range(0, 1) == 1) begin
        cmd(8'h80); addr3(8'h00, 8'(p));
        for (int i = 0; i < 3; i++) din(8'($urandom));
      end
      r = $urandom_range(0, 255);
      l = $urandom_range(1, 70);
      open_read(8'(r), 8'(p + 16 * $urandom_range(0, 15)));
      wait_ready();
      for (int k = 0; k < l; k++) rd(mem_m[p][(r + k) % 64]);
    end

    clk_n(10);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("busy_q_drained", 32'(busy_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
